// File: rtl/life_loader.sv
// life_loader: row-serial frame writer for the 10x10 toroidal life core.
//
// Rows arrive one per valid/ready beat and are assembled in a shadow buffer.
// On the final beat the whole frame is copied into grid at once, and load
// pulses for one cycle. The life core therefore only ever sees complete frames.
// A row_last beat ends a short frame, and every row after it is zero-filled.
//
// Ports
//   clk        clock; all state changes on the rising edge
//   reset      asynchronous reset, active low
//   start      starts a new frame; sampled only in IDLE
//   row_valid  row_data and row_last are valid this cycle
//   row_data   row_data[j] is cell (row_idx, j); 1 = alive
//   row_last   this beat is the final row of a short frame
//   row_ready  the loader accepts a row this cycle (FILL)
//   busy       high in FILL or COMMIT
//   load       one-cycle pulse; grid holds a newly committed frame
//   short_fr   sticky; the last committed frame ended early through row_last
//   grid       committed pattern, grid[i][j]
//
// state  | meaning
// IDLE   | waiting for start; grid shows the last committed frame
// FILL   | accepting rows into the shadow buffer
// COMMIT | single cycle after commit; load is high
module life_loader #(
    parameter int N = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 row_valid,
    input  logic [N-1:0]         row_data,
    input  logic                 row_last,
    output logic                 row_ready,
    output logic                 busy,
    output logic                 load,
    output logic                 short_fr,
    output logic [N-1:0][N-1:0]  grid
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    localparam logic [3:0] LAST_IDX = 4'(N - 1);

    state_t               state;
    state_t               state_nx;
    logic [3:0]           row_idx;
    logic [N-1:0][N-1:0]  shadow;
    logic [N-1:0][N-1:0]  merged;
    logic                 beat;
    logic                 final_beat;

    assign beat       = row_valid && (state == FILL);
    assign final_beat = beat && ((row_idx == LAST_IDX) || row_last);

    // Frame as it will be committed: rows already captured, the current beat's
    // row, and zeros for any rows a short frame never sent.
    always_comb begin
        merged = '0;
        for (int r = 0; r < N; r++) begin
            if (4'(r) == row_idx) begin
                merged[r] = row_data;
            end else if (4'(r) < row_idx) begin
                merged[r] = shadow[r];
            end else begin
                merged[r] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        row_ready = 1'b0;
        busy      = 1'b0;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = FILL;
                end
            end
            FILL: begin
                row_ready = 1'b1;
                busy      = 1'b1;
                if (final_beat) begin
                    state_nx = COMMIT;
                end
            end
            COMMIT: begin
                busy     = 1'b1;
                load     = 1'b1;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_idx  <= '0;
            shadow   <= '0;
            grid     <= '0;
            short_fr <= 1'b0;
        end else begin
            if ((state == IDLE) && start) begin
                row_idx <= '0;
                shadow  <= '0;
            end
            if (beat) begin
                shadow[row_idx] <= row_data;
                if (final_beat) begin
                    grid     <= merged;
                    short_fr <= (row_idx != LAST_IDX);
                end else begin
                    row_idx <= row_idx + 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_life_loader.sv
// Directed testbench for life_loader. Inputs are driven 1 ns after the rising
// edge, and outputs are checked at that same point.
module tb_life_loader;

    localparam int N = 10;

    logic                clk = 1'b0;
    logic                reset;
    logic                start;
    logic                row_valid;
    logic [N-1:0]        row_data;
    logic                row_last;
    logic                row_ready;
    logic                busy;
    logic                load;
    logic                short_fr;
    logic [N-1:0][N-1:0] grid;

    int ncmp = 0;
    int nerr = 0;

    life_loader #(.N(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .row_valid (row_valid),
        .row_data  (row_data),
        .row_last  (row_last),
        .row_ready (row_ready),
        .busy      (busy),
        .load      (load),
        .short_fr  (short_fr),
        .grid      (grid)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chkg(input string tag, input logic [N-1:0][N-1:0] obs,
                        input logic [N-1:0][N-1:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [N-1:0] d, input logic last);
        row_valid = 1'b1;
        row_data  = d;
        row_last  = last;
        step();
        row_valid = 1'b0;
        row_last  = 1'b0;
        row_data  = '0;
    endtask

    task automatic begin_frame();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    logic [N-1:0][N-1:0] exp_g;
    logic [N-1:0][N-1:0] prev_g;
    logic [N-1:0]        rnd_rows [N] = '{10'h155, 10'h2AA, 10'h0F0, 10'h30C, 10'h001,
                                          10'h200, 10'h3FF, 10'h123, 10'h0CA, 10'h11F};
    int                  hs;
    int                  k;
    logic                v;
    logic                seen_load;

    initial begin
        reset     = 1'b0;
        start     = 1'b0;
        row_valid = 1'b0;
        row_data  = '0;
        row_last  = 1'b0;
        #2;
        chkg("rst_grid", grid, '0);
        chk1("rst_load", load, 1'b0);
        chk1("rst_ready", row_ready, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_short", short_fr, 1'b0);
        step();
        reset = 1'b1;
        step();

        // Full diagonal frame, back-to-back beats
        begin_frame();
        chk1("diag_ready", row_ready, 1'b1);
        chk1("diag_busy", busy, 1'b1);
        for (int i = 0; i < N; i++) begin
            chk1("diag_noload", load, 1'b0);
            chkg("diag_grid_hold", grid, '0);
            beat(10'h001 << i, 1'b0);
        end
        exp_g = '0;
        for (int i = 0; i < N; i++) exp_g[i][i] = 1'b1;
        chk1("diag_load", load, 1'b1);
        chk1("diag_commit_ready", row_ready, 1'b0);
        chk1("diag_commit_busy", busy, 1'b1);
        chkg("diag_grid", grid, exp_g);
        chk1("diag_short", short_fr, 1'b0);
        step();
        chk1("diag_load_end", load, 1'b0);
        chk1("diag_idle_busy", busy, 1'b0);
        chkg("diag_grid_keep", grid, exp_g);

        // Glider as a short frame
        begin_frame();
        beat(10'h002, 1'b0);
        beat(10'h004, 1'b0);
        chk1("gl_noload", load, 1'b0);
        beat(10'h007, 1'b1);
        exp_g = '0;
        exp_g[0] = 10'h002;
        exp_g[1] = 10'h004;
        exp_g[2] = 10'h007;
        chk1("gl_load", load, 1'b1);
        chkg("gl_grid", grid, exp_g);
        chk1("gl_short", short_fr, 1'b1);
        step();
        chk1("gl_load_end", load, 1'b0);
        chk1("gl_idle", busy, 1'b0);

        // Random valid gaps over one full frame
        prev_g = grid;
        begin_frame();
        hs = 0;
        k = 0;
        seen_load = 1'b0;
        for (int c = 0; c < 300 && !seen_load; c++) begin
            v = 1'($urandom_range(0, 1));
            row_valid = v;
            row_data  = (k < N) ? rnd_rows[k] : '0;
            if (v && row_ready) begin
                hs++;
                k++;
            end
            step();
            row_valid = 1'b0;
            if (load) begin
                seen_load = 1'b1;
            end else begin
                chkg("rnd_grid_hold", grid, prev_g);
            end
        end
        chk1("rnd_load_seen", seen_load, 1'b1);
        chk1("rnd_hs_count", hs == N, 1'b1);
        for (int i = 0; i < N; i++) exp_g[i] = rnd_rows[i];
        chkg("rnd_grid", grid, exp_g);
        chk1("rnd_short", short_fr, 1'b0);
        step();

        // Frame A all ones, start pulsed in COMMIT
        begin_frame();
        for (int i = 0; i < N; i++) beat(10'h3FF, 1'b0);
        exp_g = '1;
        chk1("a_load", load, 1'b1);
        chkg("a_grid", grid, exp_g);
        start = 1'b1;
        step();
        start = 1'b0;
        chk1("a_commit_start_idle", busy, 1'b0);
        step();
        chk1("a_no_extra_frame", busy, 1'b0);
        chk1("a_no_extra_ready", row_ready, 1'b0);

        // Frame B all zeros, start pulsed in FILL, row_last on the final row
        begin_frame();
        for (int i = 0; i < 3; i++) beat('0, 1'b0);
        start = 1'b1;
        beat('0, 1'b0);
        start = 1'b0;
        for (int i = 4; i < N - 1; i++) begin
            chkg("b_grid_still_a", grid, exp_g);
            beat('0, 1'b0);
        end
        chk1("b_noload_before_last", load, 1'b0);
        beat('0, 1'b1);
        chk1("b_load", load, 1'b1);
        chkg("b_grid", grid, '0);
        chk1("b_short_full", short_fr, 1'b0);
        step();
        chk1("b_idle", busy, 1'b0);
        step();
        chk1("b_no_extra_frame", busy, 1'b0);

        // Single-row short frame
        begin_frame();
        beat(10'h3FF, 1'b1);
        exp_g = '0;
        exp_g[0] = 10'h3FF;
        chk1("one_load", load, 1'b1);
        chkg("one_grid", grid, exp_g);
        chk1("one_short", short_fr, 1'b1);
        step();

        // Reset after 5 beats, then a clean anti-diagonal frame
        begin_frame();
        for (int i = 0; i < 5; i++) beat(10'h3FF, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        chkg("mid_rst_grid", grid, '0);
        chk1("mid_rst_load", load, 1'b0);
        chk1("mid_rst_ready", row_ready, 1'b0);
        chk1("mid_rst_busy", busy, 1'b0);
        chk1("mid_rst_short", short_fr, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        step();
        chk1("post_rst_idle", busy, 1'b0);
        begin_frame();
        for (int i = 0; i < N; i++) beat(10'h200 >> i, 1'b0);
        exp_g = '0;
        for (int i = 0; i < N; i++) exp_g[i][N-1-i] = 1'b1;
        chk1("new_load", load, 1'b1);
        chkg("new_grid", grid, exp_g);
        chk1("new_short", short_fr, 1'b0);
        step();
        chk1("new_load_end", load, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
